// File: rtl/btb_resolve_pkg.sv
// Shared LC-3b types: machine word, BTB prediction record and resolver FSM states.
package lc3b_types;

   typedef logic [15:0] lc3b_word;

   typedef struct packed {
      lc3b_word pc;
      logic     hit;
      logic     taken;
      lc3b_word target;
   } btb_rec_t;

   typedef enum logic {
      RES_RUN     = 1'b0,
      RES_RECOVER = 1'b1
   } btb_res_state_t;

   // Fall-through address of a 16-bit instruction; wraps mod 2^16.
   function automatic lc3b_word pc_next(input lc3b_word pc);
      return pc + 16'd2;
   endfunction

endpackage

// File: rtl/btb_resolve_if.sv
// Fetch/resolve/BTB-update signal bundle between the pipeline and btb_resolve.
interface btb_resolve_if;
   import lc3b_types::*;

   logic     pred_valid;
   lc3b_word pred_pc;
   logic     pred_hit;
   logic     pred_taken;
   lc3b_word pred_target;
   logic     res_valid;
   logic     res_taken;
   lc3b_word res_target;
   logic     full;
   logic     empty;
   logic     wb_sel;
   lc3b_word wb_pc;
   lc3b_word wb_pred_addr;
   logic     wb_btb_hit;
   logic     branch_enable;
   logic     mispredict;
   lc3b_word redirect_pc;
   logic     err;

   modport master (
      output pred_valid, pred_pc, pred_hit, pred_taken, pred_target,
             res_valid, res_taken, res_target,
      input  full, empty, wb_sel, wb_pc, wb_pred_addr, wb_btb_hit,
             branch_enable, mispredict, redirect_pc, err
   );

   modport slave (
      input  pred_valid, pred_pc, pred_hit, pred_taken, pred_target,
             res_valid, res_taken, res_target,
      output full, empty, wb_sel, wb_pc, wb_pred_addr, wb_btb_hit,
             branch_enable, mispredict, redirect_pc, err
   );

endinterface

// File: rtl/btb_resolve_check.sv
// Combinational compare of the oldest prediction against the resolved outcome.
module btb_res_check
   import lc3b_types::*;
(
   input  lc3b_word pc_i,
   input  logic     taken_i,
   input  lc3b_word target_i,
   input  logic     res_taken_i,
   input  lc3b_word res_target_i,
   output logic     mispredict_o,
   output lc3b_word redirect_pc_o,
   output lc3b_word wb_pc_o
);

   // Target only matters when both sides agree the branch was taken.
   assign mispredict_o  = (taken_i != res_taken_i) ||
                          (taken_i && res_taken_i && (target_i != res_target_i));
   assign wb_pc_o       = pc_next(pc_i);
   assign redirect_pc_o = res_taken_i ? res_target_i : pc_next(pc_i);

endmodule

// File: rtl/btb_resolve.sv
// In-flight branch prediction FIFO; resolves the oldest entry, drives BTB update and flush.
module btb_resolve
   import lc3b_types::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic         clk,
   input  logic         reset_n,
   btb_resolve_if.slave bus
);

   localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   btb_rec_t       mem_q [DEPTH];
   logic [AW-1:0]  head_q, tail_q;
   logic [AW:0]    count_q;
   btb_res_state_t state_q;

   logic     wb_sel_q, wb_btb_hit_q, branch_enable_q, mispredict_q, err_q;
   lc3b_word wb_pc_q, wb_pred_addr_q, redirect_pc_q;

   btb_rec_t head_rec, push_rec;
   logic     run, is_full, is_empty, pop, push, err_set;
   logic     chk_misp;
   lc3b_word chk_redirect, chk_wb_pc;

   assign is_full  = (count_q == FULL_CNT);
   assign is_empty = (count_q == '0);
   assign run      = (state_q == RES_RUN);
   assign head_rec = mem_q[head_q];
   assign push_rec = '{pc: bus.pred_pc, hit: bus.pred_hit,
                       taken: bus.pred_taken, target: bus.pred_target};

   btb_res_check u_check (
      .pc_i          (head_rec.pc),
      .taken_i       (head_rec.taken),
      .target_i      (head_rec.target),
      .res_taken_i   (bus.res_taken),
      .res_target_i  (bus.res_target),
      .mispredict_o  (chk_misp),
      .redirect_pc_o (chk_redirect),
      .wb_pc_o       (chk_wb_pc)
   );

   // A push alongside a mispredicting pop is wrong-path fetch and is dropped silently.
   assign pop     = bus.res_valid && !is_empty && run;
   assign push    = bus.pred_valid && run && (!is_full || pop) && !(pop && chk_misp);
   assign err_set = run && ((bus.pred_valid && is_full && !pop) ||
                            (bus.res_valid && is_empty));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            mem_q[tail_q] <= push_rec;
            tail_q        <= tail_q + 1'b1;
         end
         if (pop) head_q <= head_q + 1'b1;
         if (pop && chk_misp) begin
            tail_q  <= head_q + 1'b1;
            count_q <= '0;
         end else if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RES_RUN;
      end else begin
         case (state_q)
            RES_RUN:     if (pop && chk_misp) state_q <= RES_RECOVER;
            RES_RECOVER: state_q <= RES_RUN;
            default:     state_q <= RES_RUN;
         endcase
      end
   end

   // Strobes last one cycle; 16-bit fields hold until the next resolution.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wb_sel_q        <= 1'b0;
         wb_btb_hit_q    <= 1'b0;
         branch_enable_q <= 1'b0;
         mispredict_q    <= 1'b0;
         err_q           <= 1'b0;
         wb_pc_q         <= '0;
         wb_pred_addr_q  <= '0;
         redirect_pc_q   <= '0;
      end else begin
         wb_sel_q        <= pop;
         wb_btb_hit_q    <= pop && head_rec.hit;
         branch_enable_q <= pop && bus.res_taken;
         mispredict_q    <= pop && chk_misp;
         if (pop) begin
            wb_pc_q        <= chk_wb_pc;
            wb_pred_addr_q <= bus.res_target;
            redirect_pc_q  <= chk_redirect;
         end
         if (err_set) err_q <= 1'b1;
      end
   end

   assign bus.full          = is_full;
   assign bus.empty         = is_empty;
   assign bus.wb_sel        = wb_sel_q;
   assign bus.wb_pc         = wb_pc_q;
   assign bus.wb_pred_addr  = wb_pred_addr_q;
   assign bus.wb_btb_hit    = wb_btb_hit_q;
   assign bus.branch_enable = branch_enable_q;
   assign bus.mispredict    = mispredict_q;
   assign bus.redirect_pc   = redirect_pc_q;
   assign bus.err           = err_q;

endmodule

// File: tb/tb_btb_resolve.sv
// Scoreboard bench for btb_resolve: a queue model predicts each BTB update and flush.
module tb_btb_resolve;
   import lc3b_types::*;

   localparam int DEPTH = 4;

   typedef struct {
      logic [15:0] pc;
      logic        hit;
      logic        taken;
      logic [15:0] tgt;
   } rec_t;

   typedef struct packed {
      logic        sel;
      logic [15:0] wb_pc;
      logic [15:0] pa;
      logic        hit;
      logic        be;
      logic        mis;
      logic [15:0] rpc;
   } out_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   btb_resolve_if bus ();
   btb_resolve #(.DEPTH(DEPTH)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   rec_t mq[$];
   out_t exp_q[$];
   logic m_rec = 1'b0;
   logic err_m = 1'b0;
   int   chk_cnt = 0;
   int   pass_cnt = 0;
   out_t o, e;

   function automatic out_t obs();
      return '{sel: bus.wb_sel, wb_pc: bus.wb_pc, pa: bus.wb_pred_addr,
               hit: bus.wb_btb_hit, be: bus.branch_enable,
               mis: bus.mispredict, rpc: bus.redirect_pc};
   endfunction

   task automatic drive(input logic pv, input logic [15:0] pc, input logic hit,
                        input logic tk, input logic [15:0] tgt,
                        input logic rv, input logic rtk, input logic [15:0] rtgt);
      bus.pred_valid = pv;  bus.pred_pc = pc;    bus.pred_hit = hit;
      bus.pred_taken = tk;  bus.pred_target = tgt;
      bus.res_valid  = rv;  bus.res_taken = rtk; bus.res_target = rtgt;
   endtask

   // Advance the reference queue model with the driven inputs, then clock once.
   task automatic step();
      int   sz;
      logic p_pop, p_push, mis, rec_n;
      rec_t h;
      sz     = mq.size();
      p_pop  = bus.res_valid && sz > 0 && !m_rec;
      p_push = bus.pred_valid && !m_rec && (sz < DEPTH || p_pop);
      if (!m_rec && ((bus.pred_valid && sz == DEPTH && !p_pop) || (bus.res_valid && sz == 0)))
         err_m = 1'b1;
      rec_n = 1'b0;
      if (p_pop) begin
         h   = mq.pop_front();
         mis = (h.taken != bus.res_taken) ||
               (h.taken && bus.res_taken && h.tgt != bus.res_target);
         exp_q.push_back('{sel: 1'b1, wb_pc: h.pc + 16'd2, pa: bus.res_target,
                           hit: h.hit, be: bus.res_taken, mis: mis,
                           rpc: bus.res_taken ? bus.res_target : h.pc + 16'd2});
         if (mis) begin
            mq.delete();
            p_push = 1'b0;
            rec_n  = 1'b1;
         end
      end
      if (p_push)
         mq.push_back('{pc: bus.pred_pc, hit: bus.pred_hit,
                        taken: bus.pred_taken, tgt: bus.pred_target});
      m_rec = rec_n;
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      mq.delete();
      exp_q.delete();
      m_rec = 1'b0;
      err_m = 1'b0;
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      model_clear();
      o = obs();
      chk_cnt++;
      if (o !== '0 || bus.full !== 1'b0 || bus.empty !== 1'b1 || bus.err !== 1'b0)
         $display("FAIL reset outs=%h full=%b empty=%b err=%b exp outs=0 full=0 empty=1 err=0",
                  o, bus.full, bus.empty, bus.err);
      else pass_cnt++;
   endtask

   task automatic test_hit_correct();
      drive(1, 16'h1000, 1, 1, 16'h1040, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0, 1, 1, 16'h1040);         step();
      o = obs(); e = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk_cnt++;
      if (o !== e || e.wb_pc !== 16'h1002 || e.mis !== 1'b0)
         $display("FAIL hit_correct got %h exp %h", o, e);
      else pass_cnt++;
      drive(0, 0, 0, 0, 0, 0, 0, 0); step();
      chk_cnt++;
      if (bus.wb_sel !== 1'b0 || bus.wb_pc !== 16'h1002 || bus.empty !== 1'b1)
         $display("FAIL strobe_drop wb_sel=%b wb_pc=%h empty=%b exp 0/1002/1",
                  bus.wb_sel, bus.wb_pc, bus.empty);
      else pass_cnt++;
   endtask

   task automatic test_mispredict_dir();
      drive(1, 16'h2000, 0, 0, 16'h0000, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0, 1, 1, 16'h2080);         step();
      o = obs(); e = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk_cnt++;
      if (o !== e || e.rpc !== 16'h2080 || e.mis !== 1'b1 || e.hit !== 1'b0)
         $display("FAIL mispredict_dir got %h exp %h", o, e);
      else pass_cnt++;
      drive(0, 0, 0, 0, 0, 0, 0, 0); step();
      chk_cnt++;
      if (bus.mispredict !== 1'b0 || bus.redirect_pc !== 16'h2080)
         $display("FAIL misp_pulse mispredict=%b redirect=%h exp 0/2080",
                  bus.mispredict, bus.redirect_pc);
      else pass_cnt++;
   endtask

   task automatic test_recover();
      drive(1, 16'h3000, 1, 1, 16'h3100, 0, 0, 0); step();
      drive(1, 16'h3010, 0, 0, 16'h0000, 0, 0, 0); step();
      drive(1, 16'h3020, 0, 0, 16'h0000, 0, 0, 0); step();
      drive(1, 16'h3030, 0, 0, 16'h0000, 1, 0, 16'h0000); step();
      o = obs(); e = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk_cnt++;
      if (o !== e || e.rpc !== 16'h3002 || bus.empty !== 1'b1)
         $display("FAIL recover_flush got %h empty=%b exp %h empty=1", o, bus.empty, e);
      else pass_cnt++;
      drive(1, 16'h3040, 0, 0, 16'h0000, 1, 0, 16'h0000); step();
      chk_cnt++;
      if (bus.empty !== 1'b1 || bus.err !== 1'b0 || bus.wb_sel !== 1'b0)
         $display("FAIL recover_ignore empty=%b err=%b wb_sel=%b exp 1/0/0",
                  bus.empty, bus.err, bus.wb_sel);
      else pass_cnt++;
      drive(1, 16'h3050, 0, 0, 16'h0000, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0, 1, 0, 16'h0000);         step();
      o = obs(); e = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk_cnt++;
      if (o !== e || e.wb_pc !== 16'h3052)
         $display("FAIL recover_resume got %h exp %h", o, e);
      else pass_cnt++;
      drive(0, 0, 0, 0, 0, 0, 0, 0); step();
   endtask

   task automatic test_full_wrap();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 16'h4000 + 16'(2*i), i[0], 0, 16'h0000, 0, 0, 0); step();
      end
      chk_cnt++;
      if (bus.full !== 1'b1 || bus.empty !== 1'b0)
         $display("FAIL fill full=%b empty=%b exp 1/0", bus.full, bus.empty);
      else pass_cnt++;
      drive(1, 16'h4008, 1, 0, 16'h0000, 1, 0, 16'h0000); step();
      o = obs(); e = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk_cnt++;
      if (o !== e || bus.full !== 1'b1 || e.wb_pc !== 16'h4002)
         $display("FAIL push_pop_full got %h full=%b exp %h full=1", o, bus.full, e);
      else pass_cnt++;
      drive(1, 16'h400A, 0, 0, 16'h0000, 0, 0, 0); step();
      chk_cnt++;
      if (bus.err !== err_m || err_m !== 1'b1 || bus.full !== 1'b1 || bus.wb_sel !== 1'b0)
         $display("FAIL overflow err=%b full=%b wb_sel=%b exp 1/1/0",
                  bus.err, bus.full, bus.wb_sel);
      else pass_cnt++;
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 0, 0, 0, 0, 1, 0, 16'h0000); step();
         o = obs(); e = 'x;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         chk_cnt++;
         if (o !== e || e.wb_pc !== 16'h4004 + 16'(2*i))
            $display("FAIL wrap_order[%0d] got %h exp %h", i, o, e);
         else pass_cnt++;
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0); step();
      chk_cnt++;
      if (bus.empty !== 1'b1 || bus.full !== 1'b0)
         $display("FAIL drain empty=%b full=%b exp 1/0", bus.empty, bus.full);
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      drive(1, 16'h5000, 1, 1, 16'h5100, 0, 0, 0); step();
      drive(1, 16'h5010, 1, 1, 16'h5200, 1, 1, 16'h5100); step();
      void'(exp_q.pop_front());
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1 reset_n = 1'b0;
      #1;
      o = obs();
      chk_cnt++;
      if (o !== '0 || bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.err !== 1'b0)
         $display("FAIL async_reset outs=%h empty=%b full=%b err=%b exp 0/1/0/0",
                  o, bus.empty, bus.full, bus.err);
      else pass_cnt++;
      #1 reset_n = 1'b1;
      model_clear();
      @(posedge clk); #1;
   endtask

   task automatic test_empty_err();
      drive(0, 0, 0, 0, 0, 1, 1, 16'h6000); step();
      chk_cnt++;
      if (bus.wb_sel !== 1'b0 || bus.err !== err_m || err_m !== 1'b1 || bus.empty !== 1'b1)
         $display("FAIL empty_err wb_sel=%b err=%b empty=%b exp 0/1/1",
                  bus.wb_sel, bus.err, bus.empty);
      else pass_cnt++;
      drive(0, 0, 0, 0, 0, 0, 0, 0); step();
   endtask

   task automatic test_pc_wrap();
      drive(1, 16'hFFFE, 1, 1, 16'h1234, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0, 1, 0, 16'h0000);         step();
      o = obs(); e = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk_cnt++;
      if (o !== e || bus.redirect_pc !== 16'h0000 || bus.mispredict !== 1'b1)
         $display("FAIL pc_wrap got %h exp %h", o, e);
      else pass_cnt++;
      drive(0, 0, 0, 0, 0, 0, 0, 0); step();
   endtask

   task automatic test_target_mismatch();
      drive(1, 16'h7000, 1, 1, 16'h7040, 0, 0, 0); step();
      drive(1, 16'h7002, 0, 0, 16'h0000, 1, 1, 16'h7080); step();
      o = obs(); e = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk_cnt++;
      if (o !== e || e.mis !== 1'b1 || bus.empty !== 1'b1 || bus.redirect_pc !== 16'h7080)
         $display("FAIL target_mismatch got %h empty=%b exp %h empty=1", o, bus.empty, e);
      else pass_cnt++;
      drive(0, 0, 0, 0, 0, 0, 0, 0); step();
   endtask

   initial begin
      test_reset();
      test_hit_correct();
      test_mispredict_dir();
      test_recover();
      test_full_wrap();
      test_async_reset();
      test_empty_err();
      test_pc_wrap();
      test_target_mismatch();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
